// File: rtl/pipe_pkg.sv
// Shared types and helpers for the pipeline destination tracker.
// An entry holds one stage's {valid, dest}; r0 is never tracked.
package pipe_pkg;

  localparam int REG_WIDTH = 6;
  localparam int NUM_REGS  = 2 ** REG_WIDTH;

  localparam logic [REG_WIDTH-1:0] ZERO_REG = {REG_WIDTH{1'b0}};

  typedef struct packed {
    logic                 valid;
    logic [REG_WIDTH-1:0] dest;
  } dest_entry_t;

  localparam dest_entry_t BUBBLE = '{valid: 1'b0, dest: ZERO_REG};

  // A writer to r0 is folded into a bubble so it never shows up as pending.
  function automatic dest_entry_t make_entry(input logic                 dec_valid,
                                             input logic                 op_writes,
                                             input logic [REG_WIDTH-1:0] op_dest);
    dest_entry_t e;
    e.valid = dec_valid & op_writes & (op_dest != ZERO_REG);
    e.dest  = e.valid ? op_dest : ZERO_REG;
    return e;
  endfunction

  function automatic logic [REG_WIDTH-1:0] visible_dest(input dest_entry_t e);
    return e.valid ? e.dest : ZERO_REG;
  endfunction

endpackage

// File: rtl/dest_stage_reg.sv
// Single pipeline-stage destination entry with clear > load > hold priority.
// Reset (synchronous, active-low) overrides both controls.
module dest_stage_reg
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        n_reset,
  input  logic        load_i,
  input  logic        clear_i,
  input  dest_entry_t d_i,
  output dest_entry_t q_o
);

  dest_entry_t entry_q;
  dest_entry_t entry_d;

  always_comb begin
    entry_d = entry_q;
    if (clear_i) begin
      entry_d = BUBBLE;
    end else if (load_i) begin
      entry_d = d_i;
    end else begin
      entry_d = entry_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      entry_q <= BUBBLE;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign q_o = entry_q;

endmodule

// File: rtl/pipe_dest_tracker.sv
// Tracks EX/M/WB destination registers; a stalled or flushed decode inserts a
// bubble into EX so the back end always drains. All outputs decode stage state.
module pipe_dest_tracker
  import pipe_pkg::dest_entry_t;
  import pipe_pkg::make_entry;
  import pipe_pkg::visible_dest;
#(
  parameter int REG_WIDTH = pipe_pkg::REG_WIDTH,
  parameter int NUM_REGS  = 2 ** REG_WIDTH
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 dec_valid_i,
  input  logic                 dec_op_writes_i,
  input  logic [REG_WIDTH-1:0] dec_op_dest_i,
  input  logic                 stall_i,
  input  logic                 flush_i,
  input  logic                 hold_i,
  output logic [REG_WIDTH-1:0] ex_op_dest_o,
  output logic [REG_WIDTH-1:0] m_op_dest_o,
  output logic [REG_WIDTH-1:0] wb_op_dest_o,
  output logic [NUM_REGS-1:0]  pending_o,
  output logic [1:0]           inflight_count_o,
  output logic                 wb_commit_valid_o,
  output logic [REG_WIDTH-1:0] wb_commit_dest_o,
  output logic                 drained_o
);

  dest_entry_t ex_q;
  dest_entry_t m_q;
  dest_entry_t wb_q;
  dest_entry_t ex_in;

  logic advance;
  logic ex_kill;

  logic [NUM_REGS-1:0] pending_bits;
  logic [1:0]          count_bits;

  // Hold freezes everything; flush outranks stall but both just kill the EX insert.
  assign advance = ~hold_i;
  assign ex_kill = advance & (flush_i | stall_i);
  assign ex_in   = make_entry(dec_valid_i, dec_op_writes_i, dec_op_dest_i);

  dest_stage_reg u_ex (
    .clk     (clk),
    .n_reset (n_reset),
    .load_i  (advance),
    .clear_i (ex_kill),
    .d_i     (ex_in),
    .q_o     (ex_q)
  );

  dest_stage_reg u_m (
    .clk     (clk),
    .n_reset (n_reset),
    .load_i  (advance),
    .clear_i (1'b0),
    .d_i     (ex_q),
    .q_o     (m_q)
  );

  dest_stage_reg u_wb (
    .clk     (clk),
    .n_reset (n_reset),
    .load_i  (advance),
    .clear_i (1'b0),
    .d_i     (m_q),
    .q_o     (wb_q)
  );

  // Duplicate targets simply OR together, so a bit stays set until its last writer retires.
  always_comb begin
    pending_bits                = {NUM_REGS{1'b0}};
    pending_bits[ex_q.dest]     = pending_bits[ex_q.dest] | ex_q.valid;
    pending_bits[m_q.dest]      = pending_bits[m_q.dest]  | m_q.valid;
    pending_bits[wb_q.dest]     = pending_bits[wb_q.dest] | wb_q.valid;
    pending_bits[0]             = 1'b0;
    count_bits = {1'b0, ex_q.valid} + {1'b0, m_q.valid} + {1'b0, wb_q.valid};
  end

  assign ex_op_dest_o      = visible_dest(ex_q);
  assign m_op_dest_o       = visible_dest(m_q);
  assign wb_op_dest_o      = visible_dest(wb_q);
  assign pending_o         = pending_bits;
  assign inflight_count_o  = count_bits;
  assign wb_commit_valid_o = wb_q.valid;
  assign wb_commit_dest_o  = visible_dest(wb_q);
  assign drained_o         = (count_bits == 2'd0);

endmodule

// File: tb/tb_pipe_dest_tracker.sv
// Scoreboard bench: each driven cycle queues its hand-computed stage contents;
// a negedge monitor pops the entry due for that cycle and compares every output.
module tb_pipe_dest_tracker;

  localparam int RW = 6;
  localparam int NR = 64;

  logic          clk = 1'b0;
  logic          n_reset = 1'b0;
  logic          dec_valid_i = 1'b0;
  logic          dec_op_writes_i = 1'b0;
  logic [RW-1:0] dec_op_dest_i = '0;
  logic          stall_i = 1'b0;
  logic          flush_i = 1'b0;
  logic          hold_i = 1'b0;
  logic [RW-1:0] ex_op_dest_o;
  logic [RW-1:0] m_op_dest_o;
  logic [RW-1:0] wb_op_dest_o;
  logic [NR-1:0] pending_o;
  logic [1:0]    inflight_count_o;
  logic          wb_commit_valid_o;
  logic [RW-1:0] wb_commit_dest_o;
  logic          drained_o;

  typedef struct {
    int            cyc;
    logic [RW-1:0] ex;
    logic [RW-1:0] m;
    logic [RW-1:0] wb;
  } exp_t;

  exp_t exp_q[$];
  int   cyc_cnt = 0;
  int   tests = 0;
  int   fails = 0;

  pipe_dest_tracker dut (
    .clk               (clk),
    .n_reset           (n_reset),
    .dec_valid_i       (dec_valid_i),
    .dec_op_writes_i   (dec_op_writes_i),
    .dec_op_dest_i     (dec_op_dest_i),
    .stall_i           (stall_i),
    .flush_i           (flush_i),
    .hold_i            (hold_i),
    .ex_op_dest_o      (ex_op_dest_o),
    .m_op_dest_o       (m_op_dest_o),
    .wb_op_dest_o      (wb_op_dest_o),
    .pending_o         (pending_o),
    .inflight_count_o  (inflight_count_o),
    .wb_commit_valid_o (wb_commit_valid_o),
    .wb_commit_dest_o  (wb_commit_dest_o),
    .drained_o         (drained_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input int cyc, input logic [63:0] act, input logic [63:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp_v);
    end
  endtask

  // Monitor: pending/count/commit expectations follow from the hand-written stage dests.
  always @(negedge clk) begin
    while (exp_q.size() != 0 && exp_q[0].cyc <= cyc_cnt) begin
      exp_t          e;
      logic [NR-1:0] pbits;
      logic [1:0]    cnt;
      e     = exp_q.pop_front();
      pbits = '0;
      cnt   = 2'd0;
      if (e.ex != 0) begin pbits[e.ex] = 1'b1; cnt = cnt + 2'd1; end
      if (e.m  != 0) begin pbits[e.m]  = 1'b1; cnt = cnt + 2'd1; end
      if (e.wb != 0) begin pbits[e.wb] = 1'b1; cnt = cnt + 2'd1; end
      if (e.cyc != cyc_cnt) begin
        tests++;
        fails++;
        $display("FAIL sched: entry for cycle %0d checked at cycle %0d", e.cyc, cyc_cnt);
      end
      check("ex_dest",      e.cyc, 64'(ex_op_dest_o),      64'(e.ex));
      check("m_dest",       e.cyc, 64'(m_op_dest_o),       64'(e.m));
      check("wb_dest",      e.cyc, 64'(wb_op_dest_o),      64'(e.wb));
      check("pending",      e.cyc, pending_o,              pbits);
      check("count",        e.cyc, 64'(inflight_count_o),  64'(cnt));
      check("commit_valid", e.cyc, 64'(wb_commit_valid_o), 64'(e.wb != 0));
      check("commit_dest",  e.cyc, 64'(wb_commit_dest_o),  64'(e.wb));
      check("drained",      e.cyc, 64'(drained_o),         64'(cnt == 2'd0));
    end
  end

  task automatic step(input logic v, input logic w, input logic [RW-1:0] d,
                      input logic st, input logic fl, input logic hd, input logic rn,
                      input logic [RW-1:0] eex, input logic [RW-1:0] em, input logic [RW-1:0] ewb);
    exp_t e;
    dec_valid_i     = v;
    dec_op_writes_i = w;
    dec_op_dest_i   = d;
    stall_i         = st;
    flush_i         = fl;
    hold_i          = hd;
    n_reset         = rn;
    e.cyc = cyc_cnt + 1;
    e.ex  = eex;
    e.m   = em;
    e.wb  = ewb;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [RW-1:0] d, input logic [RW-1:0] eex,
                       input logic [RW-1:0] em, input logic [RW-1:0] ewb);
    step(1'b1, 1'b1, d, 1'b0, 1'b0, 1'b0, 1'b1, eex, em, ewb);
  endtask

  task automatic idle(input logic [RW-1:0] eex, input logic [RW-1:0] em, input logic [RW-1:0] ewb);
    step(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, eex, em, ewb);
  endtask

  initial begin
    #1;
    // Reset with decode active
    step(1'b1, 1'b1, 6'd5, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 6'd0);
    step(1'b1, 1'b1, 6'd5, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 6'd0);
    // Flow 5,7,9
    issue(6'd5, 6'd5, 6'd0, 6'd0);
    issue(6'd7, 6'd7, 6'd5, 6'd0);
    issue(6'd9, 6'd9, 6'd7, 6'd5);
    idle(6'd0, 6'd9, 6'd7);
    idle(6'd0, 6'd0, 6'd9);
    idle(6'd0, 6'd0, 6'd0);
    // Stall bubble
    issue(6'd3, 6'd3, 6'd0, 6'd0);
    step(1'b1, 1'b1, 6'd4, 1'b1, 1'b0, 1'b0, 1'b1, 6'd0, 6'd3, 6'd0);
    step(1'b1, 1'b1, 6'd4, 1'b1, 1'b0, 1'b0, 1'b1, 6'd0, 6'd0, 6'd3);
    issue(6'd4, 6'd4, 6'd0, 6'd0);
    idle(6'd0, 6'd4, 6'd0);
    idle(6'd0, 6'd0, 6'd4);
    idle(6'd0, 6'd0, 6'd0);
    // Flush outranks stall, dest 8 never enters
    issue(6'd6, 6'd6, 6'd0, 6'd0);
    issue(6'd12, 6'd12, 6'd6, 6'd0);
    step(1'b1, 1'b1, 6'd8, 1'b1, 1'b1, 1'b0, 1'b1, 6'd0, 6'd12, 6'd6);
    idle(6'd0, 6'd0, 6'd12);
    idle(6'd0, 6'd0, 6'd0);
    // Hold with flush asserted freezes all stages
    issue(6'd3, 6'd3, 6'd0, 6'd0);
    issue(6'd2, 6'd2, 6'd3, 6'd0);
    issue(6'd1, 6'd1, 6'd2, 6'd3);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 6'd5, 1'b0, 1'b1, 1'b1, 1'b1, 6'd1, 6'd2, 6'd3);
    end
    idle(6'd0, 6'd1, 6'd2);
    idle(6'd0, 6'd0, 6'd1);
    idle(6'd0, 6'd0, 6'd0);
    // r0 and duplicates
    issue(6'd0, 6'd0, 6'd0, 6'd0);
    issue(6'd10, 6'd10, 6'd0, 6'd0);
    issue(6'd10, 6'd10, 6'd10, 6'd0);
    idle(6'd0, 6'd10, 6'd10);
    idle(6'd0, 6'd0, 6'd10);
    idle(6'd0, 6'd0, 6'd0);
    // Non-writing valid instruction is a bubble
    step(1'b1, 1'b0, 6'd11, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 6'd0, 6'd0);
    // Full pipeline drains under continuous stall within 3 edges
    issue(6'd20, 6'd20, 6'd0, 6'd0);
    issue(6'd21, 6'd21, 6'd20, 6'd0);
    issue(6'd22, 6'd22, 6'd21, 6'd20);
    step(1'b1, 1'b1, 6'd23, 1'b1, 1'b0, 1'b0, 1'b1, 6'd0, 6'd22, 6'd21);
    step(1'b1, 1'b1, 6'd23, 1'b1, 1'b0, 1'b0, 1'b1, 6'd0, 6'd0, 6'd22);
    step(1'b1, 1'b1, 6'd23, 1'b1, 1'b0, 1'b0, 1'b1, 6'd0, 6'd0, 6'd0);
    // Mid-operation reset overrides hold
    issue(6'd30, 6'd30, 6'd0, 6'd0);
    issue(6'd31, 6'd31, 6'd30, 6'd0);
    step(1'b1, 1'b1, 6'd32, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 6'd0, 6'd0);
    idle(6'd0, 6'd0, 6'd0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations never checked, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
